// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: holds one retiring entry, drives the register-file write,
// the bypass path and the retired-instruction counter, and freezes on ebreak.
module wb_commit_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             ws_valid,
    output logic             ws_ready,
    input  logic [XLEN-1:0]  ws_bits_pc,
    input  logic             ws_bits_rf_we,
    input  logic [RF_AW-1:0] ws_bits_rf_waddr,
    input  logic [XLEN-1:0]  ws_bits_rf_wdata,
    input  logic             ws_bits_is_break,

    output logic [XLEN-1:0]  torf_pc,
    output logic             torf_rf_we,
    output logic [RF_AW-1:0] torf_rf_waddr,
    output logic [XLEN-1:0]  torf_rf_wdata,
    output logic             torf_is_break,
    output logic             torf_valid,

    output logic             fwd_valid,
    output logic [RF_AW-1:0] fwd_waddr,
    output logic [XLEN-1:0]  fwd_wdata,

    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [XLEN-1:0]  halt_pc
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t             state, state_next;

    logic               valid_r;
    logic [XLEN-1:0]    pc_r;
    logic               we_r;
    logic [RF_AW-1:0]   waddr_r;
    logic [XLEN-1:0]    wdata_r;
    logic               is_break_r;
    logic [CNT_W-1:0]   instret_r;
    logic [XLEN-1:0]    halt_pc_r;

    logic               accept;
    logic               halt_now;

    assign accept   = ws_valid && ws_ready;
    assign halt_now = (state == RUN) && valid_r && is_break_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves state_next unassigned (no latch).
        state_next = state;
        if (halt_now) begin
            state_next = HALT;
        end
    end

    always_comb begin
        ws_ready = 1'b0;
        halted   = 1'b0;
        case (state)
            RUN:     ws_ready = 1'b1;
            HALT:    halted   = 1'b1;
            default: ws_ready = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r    <= 1'b0;
            pc_r       <= '0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= '0;
            is_break_r <= 1'b0;
            instret_r  <= '0;
            halt_pc_r  <= '0;
        end else begin
            // An entry arriving on the ebreak's commit edge is dropped; the stage is frozen from then on.
            valid_r <= accept && !halt_now;
            if (accept && !halt_now) begin
                pc_r       <= ws_bits_pc;
                we_r       <= ws_bits_rf_we;
                waddr_r    <= ws_bits_rf_waddr;
                wdata_r    <= ws_bits_rf_wdata;
                is_break_r <= ws_bits_is_break;
            end
            if (valid_r) begin
                instret_r <= instret_r + CNT_W'(1);
            end
            if (halt_now) begin
                halt_pc_r <= pc_r;
            end
        end
    end

    assign torf_valid    = valid_r;
    assign torf_pc       = pc_r;
    assign torf_rf_we    = valid_r && we_r && (waddr_r != '0);
    assign torf_rf_waddr = waddr_r;
    assign torf_rf_wdata = wdata_r;
    assign torf_is_break = is_break_r;

    assign fwd_valid     = torf_rf_we;
    assign fwd_waddr     = waddr_r;
    assign fwd_wdata     = wdata_r;

    assign instret       = instret_r;
    assign halt_pc       = halt_pc_r;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed entries feed a scoreboard queue; a negedge monitor
// compares every presented commit, while the stimulus checks status outputs at fixed points.
module tb_wb_commit_stage;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             ws_valid;
    logic             ws_ready;
    logic [XLEN-1:0]  ws_bits_pc;
    logic             ws_bits_rf_we;
    logic [RF_AW-1:0] ws_bits_rf_waddr;
    logic [XLEN-1:0]  ws_bits_rf_wdata;
    logic             ws_bits_is_break;
    logic [XLEN-1:0]  torf_pc;
    logic             torf_rf_we;
    logic [RF_AW-1:0] torf_rf_waddr;
    logic [XLEN-1:0]  torf_rf_wdata;
    logic             torf_is_break;
    logic             torf_valid;
    logic             fwd_valid;
    logic [RF_AW-1:0] fwd_waddr;
    logic [XLEN-1:0]  fwd_wdata;
    logic [CNT_W-1:0] instret;
    logic             halted;
    logic [XLEN-1:0]  halt_pc;

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic             rf_we;
        logic [RF_AW-1:0] waddr;
        logic [XLEN-1:0]  wdata;
        logic             is_break;
    } commit_t;

    commit_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    wb_commit_stage #(
        .XLEN  (XLEN),
        .RF_AW (RF_AW),
        .CNT_W (CNT_W)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .ws_valid         (ws_valid),
        .ws_ready         (ws_ready),
        .ws_bits_pc       (ws_bits_pc),
        .ws_bits_rf_we    (ws_bits_rf_we),
        .ws_bits_rf_waddr (ws_bits_rf_waddr),
        .ws_bits_rf_wdata (ws_bits_rf_wdata),
        .ws_bits_is_break (ws_bits_is_break),
        .torf_pc          (torf_pc),
        .torf_rf_we       (torf_rf_we),
        .torf_rf_waddr    (torf_rf_waddr),
        .torf_rf_wdata    (torf_rf_wdata),
        .torf_is_break    (torf_is_break),
        .torf_valid       (torf_valid),
        .fwd_valid        (fwd_valid),
        .fwd_waddr        (fwd_waddr),
        .fwd_wdata        (fwd_wdata),
        .instret          (instret),
        .halted           (halted),
        .halt_pc          (halt_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of input; push the expected commit when the entry must retire.
    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic we,
                         input logic [RF_AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic brk, input logic push);
        commit_t e;
        ws_valid         = v;
        ws_bits_pc       = pc;
        ws_bits_rf_we    = we;
        ws_bits_rf_waddr = wa;
        ws_bits_rf_wdata = wd;
        ws_bits_is_break = brk;
        if (push) begin
            e.pc       = pc;
            e.rf_we    = we && (wa != '0);
            e.waddr    = wa;
            e.wdata    = wd;
            e.is_break = brk;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ws_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents a commit, it must match the queue head.
    always @(negedge clock) begin
        commit_t e;
        if (torf_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit_pc", 64'(torf_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("commit_pc",       64'(torf_pc),       64'(e.pc));
                check("commit_rf_we",    64'(torf_rf_we),    64'(e.rf_we));
                check("commit_waddr",    64'(torf_rf_waddr), 64'(e.waddr));
                check("commit_wdata",    64'(torf_rf_wdata), 64'(e.wdata));
                check("commit_is_break", 64'(torf_is_break), 64'(e.is_break));
                check("fwd_valid",       64'(fwd_valid),     64'(e.rf_we));
                check("fwd_waddr",       64'(fwd_waddr),     64'(e.waddr));
                check("fwd_wdata",       64'(fwd_wdata),     64'(e.wdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        ws_valid         = 1'b0;
        ws_bits_pc       = '0;
        ws_bits_rf_we    = 1'b0;
        ws_bits_rf_waddr = '0;
        ws_bits_rf_wdata = '0;
        ws_bits_is_break = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_ws_ready",   64'(ws_ready),      64'd1);
        check("rst_torf_valid", 64'(torf_valid),    64'd0);
        check("rst_torf_pc",    64'(torf_pc),       64'd0);
        check("rst_torf_rf_we", 64'(torf_rf_we),    64'd0);
        check("rst_torf_waddr", 64'(torf_rf_waddr), 64'd0);
        check("rst_torf_wdata", 64'(torf_rf_wdata), 64'd0);
        check("rst_torf_brk",   64'(torf_is_break), 64'd0);
        check("rst_fwd_valid",  64'(fwd_valid),     64'd0);
        check("rst_instret",    64'(instret),       64'd0);
        check("rst_halted",     64'(halted),        64'd0);
        check("rst_halt_pc",    64'(halt_pc),       64'd0);

        // Single entry, then idle
        drive(1'b1, 32'h8000_0000, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1);
        check("t1_torf_valid", 64'(torf_valid), 64'd1);
        check("t1_torf_rf_we", 64'(torf_rf_we), 64'd1);
        check("t1_fwd_waddr",  64'(fwd_waddr),  64'd5);
        idle();
        check("t1_instret",     64'(instret),    64'd1);
        check("t1_valid_clear", 64'(torf_valid), 64'd0);

        // Three back-to-back entries
        do_reset();
        drive(1'b1, 32'h8000_0004, 1'b1, 5'd1,  32'hA1, 1'b0, 1'b1);
        check("t2_ready0", 64'(ws_ready), 64'd1);
        drive(1'b1, 32'h8000_0008, 1'b1, 5'd2,  32'hB2, 1'b0, 1'b1);
        check("t2_ready1", 64'(ws_ready),   64'd1);
        check("t2_valid1", 64'(torf_valid), 64'd1);
        drive(1'b1, 32'h8000_000C, 1'b1, 5'd31, 32'hC3, 1'b0, 1'b1);
        check("t2_ready2", 64'(ws_ready),   64'd1);
        check("t2_valid2", 64'(torf_valid), 64'd1);
        idle();
        check("t2_instret", 64'(instret), 64'd3);

        // Write to x0 and a non-writing entry still retire
        drive(1'b1, 32'h8000_0100, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1);
        check("t3_torf_valid", 64'(torf_valid), 64'd1);
        check("t3_x0_rf_we",   64'(torf_rf_we), 64'd0);
        check("t3_x0_fwd",     64'(fwd_valid),  64'd0);
        drive(1'b1, 32'h8000_0104, 1'b0, 5'd3, 32'hBEEF, 1'b0, 1'b1);
        check("t3_nowe_rf_we", 64'(torf_rf_we), 64'd0);
        idle();
        check("t3_instret", 64'(instret), 64'd5);

        // ebreak followed by a valid entry that must be dropped
        drive(1'b1, 32'h8000_0010, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        check("t4_brk_commit", 64'(torf_is_break), 64'd1);
        check("t4_ready_pre",  64'(ws_ready),      64'd1);
        check("t4_halted_pre", 64'(halted),        64'd0);
        drive(1'b1, 32'h8000_0014, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        check("t4_halted",  64'(halted),     64'd1);
        check("t4_halt_pc", 64'(halt_pc),    64'h8000_0010);
        check("t4_ready",   64'(ws_ready),   64'd0);
        check("t4_valid",   64'(torf_valid), 64'd0);
        check("t4_instret", 64'(instret),    64'd6);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0018 + 32'(i * 4), 1'b1, 5'd8, 32'(i), 1'b0, 1'b0);
            check("t4_hold_valid",   64'(torf_valid), 64'd0);
            check("t4_hold_instret", 64'(instret),    64'd6);
            check("t4_hold_halt_pc", 64'(halt_pc),    64'h8000_0010);
        end

        // Reset while halted, with an entry on the input
        reset            = 1'b1;
        ws_valid         = 1'b1;
        ws_bits_pc       = 32'h8000_0200;
        ws_bits_is_break = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ws_valid = 1'b0;
        check("t5_halted",  64'(halted),     64'd0);
        check("t5_valid",   64'(torf_valid), 64'd0);
        check("t5_instret", 64'(instret),    64'd0);
        check("t5_ready",   64'(ws_ready),   64'd1);
        check("t5_halt_pc", 64'(halt_pc),    64'd0);
        idle();
        check("t5_after_valid", 64'(torf_valid), 64'd0);

        // Reset while an entry is held in the stage
        drive(1'b1, 32'h8000_0020, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
        check("t6_valid_pre", 64'(torf_valid), 64'd1);
        reset            = 1'b1;
        ws_valid         = 1'b1;
        ws_bits_pc       = 32'h8000_0024;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ws_valid = 1'b0;
        check("t6_valid",   64'(torf_valid), 64'd0);
        check("t6_instret", 64'(instret),    64'd0);
        idle();
        check("t6_after_valid",   64'(torf_valid), 64'd0);
        check("t6_after_instret", 64'(instret),    64'd0);

        // Counter wrap with CNT_W = 4
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 32'h8000_1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'(i * 3), 1'b0, 1'b1);
        end
        idle();
        check("t7_instret_max", 64'(instret), 64'd15);
        drive(1'b1, 32'h8000_2000, 1'b1, 5'd12, 32'h5A5A, 1'b0, 1'b1);
        idle();
        check("t7_instret_wrap", 64'(instret), 64'd0);

        idle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
